// File: rtl/lutram_stress_pkg.sv
// Shared types, constants and the test-pattern function for the LUTRAM
// stress tester. Imported by the tester top and its checker.
package lutram_stress_pkg;

    localparam int DATA_W     = 10;
    localparam int TILE_DEPTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        DRAIN,
        DONE
    } state_e;

    // Pass 0 writes addr^seed; pass 1 writes its complement so every bit
    // of every word is exercised at both polarities.
    function automatic logic [DATA_W-1:0] pat(
        input logic [DATA_W-1:0] addr,
        input logic [DATA_W-1:0] seed,
        input logic              pass
    );
        logic [DATA_W-1:0] p;
        p = addr ^ seed;
        return pass ? ~p : p;
    endfunction

endpackage

// File: rtl/lutram_stress_checker.sv
// Read-back checker: captures one read per cycle, compares a cycle later,
// keeps a saturating mismatch count and the address of the first mismatch.
// Ports: clk, rst_n; clr_i clears results; cap_en_i/rdat_i/exp_i/addr_i
// form the capture stage; err_cnt_o, err_cnt_nxt_o (value after this edge),
// first_err_addr_o.
module lutram_stress_checker
    import lutram_stress_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              cap_en_i,
    input  logic [DATA_W-1:0] rdat_i,
    input  logic [DATA_W-1:0] exp_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [15:0]       err_cnt_o,
    output logic [15:0]       err_cnt_nxt_o,
    output logic [ADDR_W-1:0] first_err_addr_o
);

    logic              vld_q;
    logic [DATA_W-1:0] rdat_q;
    logic [DATA_W-1:0] exp_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       err_cnt_q;
    logic [15:0]       err_cnt_d;
    logic [ADDR_W-1:0] first_q;
    logic [ADDR_W-1:0] first_d;
    logic              mis;

    assign mis = vld_q && (rdat_q != exp_q);

    always_comb begin
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        if (clr_i) begin
            err_cnt_d = '0;
            first_d   = '0;
        end else if (mis) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            // A zero count means nothing has been recorded yet this test.
            if (err_cnt_q == 16'd0) begin
                first_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            rdat_q    <= '0;
            exp_q     <= '0;
            addr_q    <= '0;
            err_cnt_q <= '0;
            first_q   <= '0;
        end else begin
            vld_q     <= cap_en_i;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            if (cap_en_i) begin
                rdat_q <= rdat_i;
                exp_q  <= exp_i;
                addr_q <= addr_i;
            end
        end
    end

    assign err_cnt_o        = err_cnt_q;
    assign err_cnt_nxt_o    = err_cnt_d;
    assign first_err_addr_o = first_q;

endmodule

// File: rtl/lutram_stress_tester.sv
// Self-checking traffic generator for the LUTRAM capacity array.
// Ports: clk, rst_n, start/seed (accepted in IDLE); mem_addr/mem_we/
// mem_wdat (registered array port), mem_rdat (array read data);
// busy, done, pass_ok, err_cnt, first_err_addr (test status/results).
module lutram_stress_tester
    import lutram_stress_pkg::*;
#(
    parameter int LUTRAM16X10 = 314,
    parameter int ADDR_W =
        ($clog2(LUTRAM16X10 * TILE_DEPTH) < 4) ? 4
                                               : $clog2(LUTRAM16X10 * TILE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdat,
    input  logic [DATA_W-1:0] mem_rdat,
    output logic              busy,
    output logic              done,
    output logic              pass_ok,
    output logic [15:0]       err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int DEPTH = LUTRAM16X10 * TILE_DEPTH;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] seed_q, seed_d;
    logic              pass_ok_q, pass_ok_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              clr;
    logic              last;
    logic              wr_d, rw_d, pass_d;
    logic              cap_en;
    logic [DATA_W-1:0] cap_exp;
    logic [15:0]       err_cnt_nxt;

    assign last = (cnt_q == LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seed_d    = seed_q;
        pass_ok_d = pass_ok_q;
        clr       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WR0;
                    cnt_d     = '0;
                    seed_d    = seed;
                    pass_ok_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            WR0, RD0, WR1, RD1: begin
                cnt_d = last ? '0 : cnt_q + ADDR_W'(1);
                if (last) begin
                    unique case (state_q)
                        WR0:     state_d = RD0;
                        RD0:     state_d = WR1;
                        WR1:     state_d = RD1;
                        default: state_d = DRAIN;
                    endcase
                end
            end
            DRAIN: begin
                // Use the post-edge count so the final RD1 check is included.
                state_d   = DONE;
                pass_ok_d = (err_cnt_nxt == 16'd0);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Array port is computed from next-state values so it leaves flops.
    always_comb begin
        wr_d   = (state_d == WR0) || (state_d == WR1);
        rw_d   = wr_d || (state_d == RD0) || (state_d == RD1);
        pass_d = (state_d == WR1) || (state_d == RD1);
        we_d   = wr_d;
        addr_d = rw_d ? cnt_d : '0;
        wdat_d = wr_d ? pat(DATA_W'(cnt_d), seed_d, pass_d) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seed_q    <= '0;
            pass_ok_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seed_q    <= seed_d;
            pass_ok_q <= pass_ok_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
        end
    end

    assign cap_en  = (state_q == RD0) || (state_q == RD1);
    assign cap_exp = pat(DATA_W'(cnt_q), seed_q, state_q == RD1);

    lutram_stress_checker #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr_i            (clr),
        .cap_en_i         (cap_en),
        .rdat_i           (mem_rdat),
        .exp_i            (cap_exp),
        .addr_i           (cnt_q),
        .err_cnt_o        (err_cnt),
        .err_cnt_nxt_o    (err_cnt_nxt),
        .first_err_addr_o (first_err_addr)
    );

    assign mem_we   = we_q;
    assign mem_addr = addr_q;
    assign mem_wdat = wdat_q;
    assign busy     = (state_q != IDLE) && (state_q != DONE);
    assign done     = (state_q == DONE);
    assign pass_ok  = pass_ok_q;

endmodule

// File: tb/tb_lutram_stress_tester.sv
// Bench: tester paired with a 32-word behavioural array with fault hooks;
// scoreboard queues for write beats and end-of-test results.
module tb_lutram_stress_tester;

    localparam int DW = 10;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] seed;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdat;
    logic [DW-1:0] mem_rdat;
    logic          busy;
    logic          done;
    logic          pass_ok;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    // fault modes: 0 healthy, 1 single stuck bit, 2 read data forced to 0
    int            fmode = 0;
    logic [AW-1:0] f_addr = '0;
    int            f_bit = 0;
    logic          f_val = 1'b0;

    logic [DW-1:0] arr [D];

    typedef struct {
        logic [15:0]   err;
        logic [AW-1:0] first;
        logic          pok;
        longint        dcyc;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    lutram_stress_tester #(
        .LUTRAM16X10 (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdat       (mem_wdat),
        .mem_rdat       (mem_rdat),
        .busy           (busy),
        .done           (done),
        .pass_ok        (pass_ok),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_we) arr[mem_addr] <= mem_wdat;
    end

    always_comb begin
        logic [DW-1:0] r;
        r = arr[mem_addr];
        if (fmode == 1 && mem_addr == f_addr) r[f_bit] = f_val;
        if (fmode == 2) r = '0;
        mem_rdat = r;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected result from the test's rules: every word written with the
    // pattern, read back through the fault, count differing words.
    function automatic exp_t model(input logic [DW-1:0] s, input int mode,
                                   input logic [AW-1:0] fa, input int fb,
                                   input logic fv, input int pre);
        exp_t e;
        int cnt;
        logic [DW-1:0] w;
        logic [DW-1:0] r;
        cnt = pre;
        e.first = '0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < D; a++) begin
                w = DW'(a) ^ s;
                if (p == 1) w = ~w;
                r = w;
                if (mode == 1 && a == int'(fa)) r[fb] = fv;
                if (mode == 2) r = '0;
                if (r != w) begin
                    if (cnt == 0) e.first = AW'(a);
                    if (cnt < 65535) cnt++;
                end
            end
        end
        e.err = 16'(cnt);
        e.pok = (cnt == 0);
        e.dcyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("wr_extra", 1, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", longint'(mem_addr), longint'(w.a));
                    chk("wr_data", longint'(mem_wdat), longint'(w.d));
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_spurious", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("err_cnt", longint'(err_cnt), longint'(e.err));
                    chk("first_err_addr", longint'(first_err_addr), longint'(e.first));
                    chk("pass_ok", longint'(pass_ok), longint'(e.pok));
                    chk("done_cycle", cyc, e.dcyc);
                    chk("busy_in_done", longint'(busy), 0);
                end
            end
        end
    end

    task automatic start_run(input logic [DW-1:0] s, input int mode,
                             input logic [AW-1:0] fa, input int fb,
                             input logic fv, input bit sat);
        exp_t e;
        fmode = mode;
        f_addr = fa;
        f_bit = fb;
        f_val = fv;
        e = model(s, mode, fa, fb, fv, sat ? 16'hFFFE : 0);
        @(negedge clk);
        e.dcyc = cyc + 130;
        exp_q.push_back(e);
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < D; a++) begin
                wr_t w;
                w.a = AW'(a);
                w.d = (DW'(a) ^ s) ^ ((p == 1) ? 10'h3FF : 10'h000);
                wr_q.push_back(w);
            end
        end
        seed = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed = DW'($urandom);
        if (sat) begin
            force dut.u_chk.err_cnt_q = 16'hFFFE;
            @(negedge clk);
            release dut.u_chk.err_cnt_q;
        end
    endtask

    task automatic wait_done();
        repeat (300) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", longint'(done), 1);
    endtask

    initial begin
        logic [DW-1:0] rs;
        rst_n = 1'b0;
        start = 1'b0;
        seed = '0;
        for (int i = 0; i < D; i++) arr[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_pass_ok", longint'(pass_ok), 0);
        chk("rst_err_cnt", longint'(err_cnt), 0);
        chk("rst_first", longint'(first_err_addr), 0);
        chk("rst_we", longint'(mem_we), 0);
        chk("rst_addr", longint'(mem_addr), 0);
        chk("rst_wdat", longint'(mem_wdat), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_run(10'h155, 0, '0, 0, 1'b0, 1'b0);
        wait_done();
        repeat (3) @(negedge clk);
        chk("pass_ok_held", longint'(pass_ok), 1);

        start_run(10'h000, 1, 5'd17, 3, 1'b1, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);

        start_run(10'h3FF, 2, '0, 0, 1'b0, 1'b1);
        wait_done();
        repeat (2) @(negedge clk);

        start_run(DW'($urandom), 0, '0, 0, 1'b0, 1'b0);
        repeat (200) begin
            @(negedge clk);
            if (busy && !mem_we && mem_addr == 5'd5) break;
        end
        chk("rd0_addr5_seen", longint'(mem_addr), 5);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        wr_q.delete();
        #1;
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_done", longint'(done), 0);
        chk("mid_rst_we", longint'(mem_we), 0);
        chk("mid_rst_addr", longint'(mem_addr), 0);
        chk("mid_rst_wdat", longint'(mem_wdat), 0);
        chk("mid_rst_err", longint'(err_cnt), 0);
        chk("mid_rst_first", longint'(first_err_addr), 0);
        chk("mid_rst_pass", longint'(pass_ok), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        start_run(DW'($urandom), 0, '0, 0, 1'b0, 1'b0);
        wait_done();
        repeat (2) @(negedge clk);

        start_run(DW'($urandom), 1, 5'd9, 0, 1'b0, 1'b0);
        repeat (2 * D + 5) @(negedge clk);
        seed = DW'($urandom);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("no_restart_busy", longint'(busy), 0);
        chk("no_restart_we", longint'(mem_we), 0);

        for (int k = 0; k < 6; k++) begin
            rs = DW'($urandom);
            start_run(rs, $urandom_range(0, 1), AW'($urandom_range(0, D - 1)),
                      $urandom_range(0, DW - 1), 1'($urandom), 1'b0);
            wait_done();
            repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk("exp_q_empty", longint'(exp_q.size()), 0);
        chk("wr_q_empty", longint'(wr_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
